// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH  = 32;
  localparam int unsigned MD_CYCLES = MD_WIDTH;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_arith(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider with final sign correction.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi_res,
  output logic [WIDTH-1:0] o_lo_res
);

  // Upper half: partial product (mul) or remainder (div); lower half: multiplier or quotient.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed = md_is_signed(i_op);
  assign w_a_mag  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};
  assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge     = w_rem_sh >= {1'b0, r_b};
  // Only the low bits matter: when w_ge holds the true difference is below r_b.
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;

  always_comb begin
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      w_acc_next = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (i_load) begin
      r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
      r_b      <= w_b_mag;
      r_a_raw  <= i_a;
      r_is_div <= md_is_div(i_op);
      r_neg_q  <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r  <= w_signed && i_a[WIDTH-1];
      r_div0   <= (i_b == '0);
    end else if (i_step) begin
      r_acc    <= w_acc_next;
    end
  end

  assign w_prod = r_neg_q ? -r_acc : r_acc;

  always_comb begin
    o_hi_res = w_prod[2*WIDTH-1:WIDTH];
    o_lo_res = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        o_lo_res = '1;
        o_hi_res = r_a_raw;
      end else begin
        o_lo_res = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        o_hi_res = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers: FSM, iteration counter and handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  md_state_e        r_state;
  md_state_e        w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_idle;
  logic             w_accept;
  logic             w_step;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && i_start && md_is_arith(i_op);
  assign w_step   = (r_state == CALC);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = CALC;
      CALC:    if (r_cnt == LastCnt) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == FIX);
      if (w_accept) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // HI/LO move only on the final fix edge or an idle move-to request.
      if (r_state == FIX) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end else if (w_idle && i_start && (i_op == MD_MTHI)) begin
        r_hi <= i_a;
      end else if (w_idle && i_start && (i_op == MD_MTLO)) begin
        r_lo <= i_a;
      end
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_step  (w_step),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_hi_res(w_hi_res),
    .o_lo_res(w_lo_res)
  );

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = !w_idle;
  assign o_done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model, per-cycle compare, directed vectors.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_op   (op),
    .i_a    (a),
    .i_b    (b),
    .o_hi   (hi),
    .o_lo   (lo),
    .o_busy (busy),
    .o_done (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state: architectural HI/LO, pending result and edges left until it lands.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic void model_calc(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y, output logic [31:0] rh,
                                     output logic [31:0] rl);
    longint          sx;
    longint          sy;
    longint          r64;
    longint unsigned u64;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = '0;
    rl = '0;
    case (o)
      MD_MULT: begin
        r64 = sx * sy;
        rh = r64[63:32];
        rl = r64[31:0];
      end
      MD_MULTU: begin
        u64 = {32'b0, x} * {32'b0, y};
        rh = u64[63:32];
        rl = u64[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (y == 32'd0) begin
          rl = '1;
          rh = x;
        end else if (o == MD_DIV) begin
          r64 = sx / sy;
          rl = r64[31:0];
          r64 = sx % sy;
          rh = r64[31:0];
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      m_hi = '0;
      m_lo = '0;
      m_cnt = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
          m_done = 1'b1;
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          model_calc(op, a, b, p_hi, p_lo);
          m_cnt = W + 1;
        end else if (op == MD_MTHI) begin
          m_hi = a;
        end else if (op == MD_MTLO) begin
          m_lo = a;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_hi", {32'b0, hi}, {32'b0, m_hi});
      check("cyc_lo", {32'b0, lo}, {32'b0, m_lo});
      check("cyc_busy", {63'b0, busy}, {63'b0, (m_cnt > 0)});
      check("cyc_done", {63'b0, done}, {63'b0, m_done});
    end
  end

  task automatic wait_done(output int nb, output bit ok);
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_arith(input string name, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int nb;
    bit ok;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, ok);
    check({name, "_done_seen"}, {63'b0, ok}, 64'd1);
    check({name, "_busy_cycles"}, 64'(nb), 64'd33);
    check({name, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
    check({name, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
    check({name, "_model_hi"}, {32'b0, m_hi}, {32'b0, exp_hi});
    check({name, "_model_lo"}, {32'b0, m_lo}, {32'b0, exp_lo});
  endtask

  initial begin
    int nb;
    bit ok;
    int ndone;
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_hi", {32'b0, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);

    run_arith("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    @(negedge clk);
    check("multu_done_width", {63'b0, done}, 64'd0);

    run_arith("mult_neg", MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    // Each following op is started in the same cycle done is high.
    run_arith("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_arith("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_arith("div_zero", MD_DIV, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_arith("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_arith("divu_zero", MD_DIVU, 32'h80000001, 32'd0, 32'h80000001, 32'hFFFFFFFF);
    run_arith("div_rem", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);

    @(negedge clk);
    start = 1'b1;
    op = MD_MTHI;
    a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", {32'b0, hi}, 64'h00000000DEADBEEF);
    check("mthi_busy", {63'b0, busy}, 64'd0);
    check("mthi_done", {63'b0, done}, 64'd0);

    start = 1'b1;
    op = 3'd7;
    a = 32'h55;
    b = 32'h3;
    @(negedge clk);
    start = 1'b0;
    check("undef_busy", {63'b0, busy}, 64'd0);

    start = 1'b1;
    op = MD_MULTU;
    a = 32'd5;
    b = 32'd6;
    @(negedge clk);
    op = MD_MTLO;
    a = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy_lo_held", {32'b0, lo}, {32'b0, m_lo});
    wait_done(nb, ok);
    check("mtlo_ign_done_seen", {63'b0, ok}, 64'd1);
    check("mtlo_ign_lo", {32'b0, lo}, 64'd30);
    check("mtlo_ign_hi", {32'b0, hi}, 64'd0);

    @(negedge clk);
    start = 1'b1;
    op = MD_DIVU;
    a = 32'd1000;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Sits in EX, directly downstream of the general register file. Operands are the file's two read-port outputs (rs → a, rt → b).
- Executes MULT, MULTU, DIV, DIVU in WIDTH+1 cycles, and MTHI/MTLO in one cycle.
- Provides HI/LO for MFHI/MFLO and drives busy so the pipeline controller stalls.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock; everything updates on posedge clk.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- start  in  1  request valid for one cycle; accepted only when busy=0.
- op  in  3  operation code (encodings in package).
- a  in  WIDTH  operand rs (from register file data1).
- b  in  WIDTH  operand rt (from register file data2).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  high while an arithmetic op is in flight.
- done  out  1  one-cycle pulse after HI/LO receive an arithmetic result.

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset takes priority over everything, including an op in flight; an aborted op never produces done.
- States:
  - IDLE → CALC on an accepted arithmetic start.
  - CALC → FIX when the counter reaches WIDTH-1.
  - FIX → IDLE unconditionally.
- Accept (edge E0, start=1, busy=0, op ∈ {MULT, MULTU, DIV, DIVU}):
  - Latch op.
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch result-sign flags: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - Clear the counter. busy=1 from E0.
- CALC, one iteration per cycle for WIDTH cycles (edges E1..E32):
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX (edge E33): apply sign correction by two's-complement negation, then write the results:
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
  - After E33: busy=0 and done=1 for exactly one cycle.
- Total latency: start edge to HI/LO visible = 33 edges; done observed in the cycle after E33.
- MTHI/MTLO with start=1 and busy=0: hi (or lo) = a at the next edge. No busy, no done.
- start while busy=1: ignored entirely (any op). The controller must hold the instruction until busy=0.
- start with an undefined op code: ignored.
- Divide by zero (b=0): completes with normal latency; lo = all ones, hi = a (raw dividend, signed or unsigned). Sign fix is not applied.
- Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0. This falls out of the magnitude algorithm; no special case is needed.
- hi/lo hold their values during CALC; the old values stay readable until E33.
- done and a new start in the same cycle: legal, since busy=0 then and the start is accepted.

Decomposition:
- Package muldiv_pkg:
  - op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - State encodings: IDLE=0, CALC=1, FIX=2.
  - MD_CYCLES = WIDTH.
- One natural sub-module: muldiv_datapath. It owns the accumulator, shift/subtract step and negation logic.
- muldiv_unit keeps the FSM, counter, handshake and HI/LO registers.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles; done pulse one cycle after.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF → hi=0xDEADBEEF next cycle, busy=0, done=0.
- Start MULTU 5×6 followed by MTLO a=0x1 issued while busy → MTLO ignored; final lo=30, hi=0.
- Start DIVU, assert rst at iteration 10 → next cycle busy=0, hi=lo=0; no done pulse within the following 40 cycles.
